stream_mux_arb: RTL and testbench

Parametrised N-channel registered stream multiplexer with valid/ready handshakes and two selection modes: explicit selector or round-robin arbitration. It is the successor to the fixed 3-input combinational data mux. It sits between several producers (e.g. writeback/forwarding sources or bus masters) and one consumer. It adds a registered output stage, per-channel backpressure, and fair arbitration.

---
 rtl/stream_mux_arb_if.sv | 31 +++
 rtl/stream_mux_arb.sv | 98 +++++++++
 tb/tb_stream_mux_arb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: handshake/data bundle between N producers, the mux and one consumer.
//   master : the mux view (drives In_Ready_o and the registered output stage)
//   slave  : the environment view (producers + consumer)
//   Mode_i / Selector_i   - selection mode and fixed-mode channel index
//   In_Valid_i / In_Data_i / In_Ready_o - per-channel input handshakes, channel k at [k*NBits +: NBits]
//   Out_Valid_o / Out_Data_o / Out_Channel_o / Out_Ready_i - output handshake
interface stream_mux_arb_if #(
  parameter int NBits     = 32,
  parameter int NChannels = 4,
  parameter int SelBits   = $clog2(NChannels)
);
  logic                        Mode_i;
  logic [SelBits-1:0]          Selector_i;
  logic [NChannels-1:0]        In_Valid_i;
  logic [NChannels*NBits-1:0]  In_Data_i;
  logic [NChannels-1:0]        In_Ready_o;
  logic                        Out_Valid_o;
  logic [NBits-1:0]            Out_Data_o;
  logic [SelBits-1:0]          Out_Channel_o;
  logic                        Out_Ready_i;

  modport master (
    input  Mode_i, Selector_i, In_Valid_i, In_Data_i, Out_Ready_i,
    output In_Ready_o, Out_Valid_o, Out_Data_o, Out_Channel_o
  );

  modport slave (
    output Mode_i, Selector_i, In_Valid_i, In_Data_i, Out_Ready_i,
    input  In_Ready_o, Out_Valid_o, Out_Data_o, Out_Channel_o
  );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream mux with fixed-select or round-robin arbitration.
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - stream_mux_arb_if.master (selection controls, per-channel inputs, registered output)
// One output register; In_Ready_o is combinational from Out_Ready_i (no skid buffer).

// Per-channel ready: asserted only for the granted channel.
module stream_mux_arb_lane #(
  parameter int SelBits = 2,
  parameter int K       = 0
) (
  input  logic               grant_en,
  input  logic [SelBits-1:0] win,
  output logic               rdy
);
  assign rdy = grant_en && (win == SelBits'(K));
endmodule

module stream_mux_arb #(
  parameter int NBits     = 32,
  parameter int NChannels = 4
) (
  input logic              clk,
  input logic              reset,
  stream_mux_arb_if.master bus
);
  localparam int SelBits = $clog2(NChannels);

  logic [NChannels-1:0][NBits-1:0] ch_data;
  logic [SelBits-1:0]              ptr;
  logic [SelBits-1:0]              win;
  logic                            win_vld;
  logic                            load;
  logic                            grant_en;
  logic                            out_vld;
  logic [NBits-1:0]                out_data;
  logic [SelBits-1:0]              out_ch;
  int                              idx;

  assign ch_data = bus.In_Data_i;
  assign load    = !out_vld || bus.Out_Ready_i;

  // Winner: fixed index when in range and valid; otherwise first valid
  // channel scanning ptr+1 .. ptr (wrapping), so the last grant goes last.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    if (!bus.Mode_i) begin
      if (int'(bus.Selector_i) < NChannels && bus.In_Valid_i[bus.Selector_i]) begin
        win_vld = 1'b1;
        win     = bus.Selector_i;
      end
    end else begin
      for (int i = 1; i <= NChannels; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NChannels) idx = idx - NChannels;
        if (!win_vld && bus.In_Valid_i[idx[SelBits-1:0]]) begin
          win_vld = 1'b1;
          win     = idx[SelBits-1:0];
        end
      end
    end
  end

  // Ready held low during reset so nothing is consumed that reset would discard.
  assign grant_en = load && win_vld && !reset;

  for (genvar k = 0; k < NChannels; k++) begin : g_lane
    stream_mux_arb_lane #(.SelBits(SelBits), .K(k)) u_lane (
      .grant_en (grant_en),
      .win      (win),
      .rdy      (bus.In_Ready_o[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      ptr      <= SelBits'(NChannels - 1);
    end else if (load) begin
      if (win_vld) begin
        out_vld  <= 1'b1;
        out_data <= ch_data[win];
        out_ch   <= win;
        ptr      <= win;   // tracked in fixed mode too, so RR resumes fairly
      end else begin
        out_vld  <= 1'b0;
      end
    end
  end

  assign bus.Out_Valid_o   = out_vld;
  assign bus.Out_Data_o    = out_data;
  assign bus.Out_Channel_o = out_ch;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed test-plan scenarios plus randomized traffic, all
// checked against a transaction-level reference model of the mux.
module tb_stream_mux_arb;
  localparam int NBits     = 32;
  localparam int NChannels = 4;
  localparam int SelBits   = $clog2(NChannels);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.NBits(NBits), .NChannels(NChannels)) bus ();

  stream_mux_arb #(.NBits(NBits), .NChannels(NChannels)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [NChannels-1:0][NBits-1:0] tb_data;
  assign bus.In_Data_i = tb_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: contents of the output register and last grant.
  logic             m_vld;
  logic [NBits-1:0] m_data;
  int               m_ch;
  int               m_last;
  int               last_grant;
  logic [NChannels-1:0] obs_rdy;
  int               seq [NChannels];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel granted this cycle by the spec's rules, or -1.
  function automatic int model_win();
    int c;
    if (!bus.Mode_i) begin
      if (int'(bus.Selector_i) < NChannels && bus.In_Valid_i[bus.Selector_i])
        return int'(bus.Selector_i);
      return -1;
    end
    for (int off = 1; off <= NChannels; off++) begin
      c = (m_last + off) % NChannels;
      if (bus.In_Valid_i[c]) return c;
    end
    return -1;
  endfunction

  // One clock: inputs are already driven; check at negedge, advance model at posedge.
  task automatic step(input logic rst_v);
    int   w;
    logic ld;
    logic [NChannels-1:0] exp_rdy;
    reset = rst_v;
    @(negedge clk);
    w  = model_win();
    ld = !m_vld || bus.Out_Ready_i;
    exp_rdy = (!rst_v && ld && w >= 0) ? (NChannels'(1) << w) : '0;
    obs_rdy = bus.In_Ready_o;
    chk("in_ready",  obs_rdy, exp_rdy);
    chk("out_valid", bus.Out_Valid_o, m_vld);
    chk("out_data",  bus.Out_Data_o, m_data);
    chk("out_chan",  bus.Out_Channel_o, m_ch);
    @(posedge clk);
    last_grant = -1;
    if (rst_v) begin
      m_vld = 1'b0; m_data = '0; m_ch = 0; m_last = NChannels - 1;
    end else if (ld) begin
      if (w >= 0) begin
        m_vld = 1'b1; m_data = tb_data[w]; m_ch = w; m_last = w;
        last_grant = w;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.In_Valid_i = '0;
    step(1'b1);
  endtask

  initial begin
    m_vld = 1'b0; m_data = '0; m_ch = 0; m_last = NChannels - 1; last_grant = -1;
    reset = 1'b1;
    bus.Mode_i = 1'b1; bus.Selector_i = '0; bus.In_Valid_i = '0; bus.Out_Ready_i = 1'b1;
    tb_data = '0;
    #1;

    // Reset held 2 cycles with all channels valid
    bus.In_Valid_i = 4'hF;
    step(1'b1);
    chk("rst_rdy0", obs_rdy, 4'h0);
    step(1'b1);
    chk("rst_rdy1", obs_rdy, 4'h0);
    chk("rst_vld",  bus.Out_Valid_o, 1'b0);
    chk("rst_data", bus.Out_Data_o, 32'h0);
    chk("rst_chan", bus.Out_Channel_o, 0);
    step(1'b0);
    chk("first_grant", last_grant, 0);

    // Fixed mode
    bus.Mode_i = 1'b0; bus.Selector_i = 2'd2; bus.In_Valid_i = 4'b0110;
    tb_data[2] = 32'hCAFE0002; bus.Out_Ready_i = 1'b1;
    step(1'b0);
    chk("fix_rdy",  obs_rdy, 4'b0100);
    chk("fix_data", bus.Out_Data_o, 32'hCAFE0002);
    chk("fix_chan", bus.Out_Channel_o, 2);
    bus.Selector_i = 2'd3;
    step(1'b0);
    chk("fix_nogrant_rdy", obs_rdy, 4'b0000);
    chk("fix_nogrant_vld", bus.Out_Valid_o, 1'b0);

    // Round-robin fairness
    do_reset();
    bus.Mode_i = 1'b1; bus.In_Valid_i = 4'hF;
    for (int k = 0; k < NChannels; k++) tb_data[k] = k;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      chk("rr_vld",  bus.Out_Valid_o, 1'b1);
      chk("rr_chan", bus.Out_Channel_o, i % NChannels);
      chk("rr_data", bus.Out_Data_o, i % NChannels);
    end

    // Backpressure: hold 5 cycles, then drain and refill in the same cycle
    do_reset();
    bus.In_Valid_i = 4'b0010; tb_data[1] = 32'h11; bus.Out_Ready_i = 1'b1;
    step(1'b0);
    bus.Out_Ready_i = 1'b0; tb_data[1] = 32'h22;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("bp_rdy",  obs_rdy, 4'b0000);
      chk("bp_hold", bus.Out_Data_o, 32'h11);
    end
    bus.Out_Ready_i = 1'b1;
    step(1'b0);
    chk("bp_refill_rdy",  obs_rdy, 4'b0010);
    chk("bp_refill_data", bus.Out_Data_o, 32'h22);
    chk("bp_refill_vld",  bus.Out_Valid_o, 1'b1);

    // Wrap and skip
    do_reset();
    bus.In_Valid_i = 4'b0100;
    step(1'b0);
    chk("wrap_g2", last_grant, 2);
    bus.In_Valid_i = 4'b0011;
    step(1'b0);
    chk("wrap_g0", last_grant, 0);
    step(1'b0);
    chk("wrap_g1", last_grant, 1);

    // Reset mid-operation discards the held word
    do_reset();
    bus.In_Valid_i = 4'b0010; tb_data[1] = 32'hDEAD; bus.Out_Ready_i = 1'b1;
    step(1'b0);
    bus.In_Valid_i = '0; bus.Out_Ready_i = 1'b0;
    step(1'b0);
    chk("mid_hold_vld",  bus.Out_Valid_o, 1'b1);
    chk("mid_hold_data", bus.Out_Data_o, 32'hDEAD);
    step(1'b1);
    chk("mid_rst_vld",  bus.Out_Valid_o, 1'b0);
    chk("mid_rst_data", bus.Out_Data_o, 32'h0);
    bus.Out_Ready_i = 1'b1;
    step(1'b0);
    chk("mid_no_replay", bus.Out_Valid_o, 1'b0);

    // Randomized traffic: each channel presents a tagged sequence number
    for (int k = 0; k < NChannels; k++) seq[k] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) bus.Mode_i = 1'($urandom_range(0, 1));
      bus.Selector_i  = SelBits'($urandom_range(0, NChannels - 1));
      bus.In_Valid_i  = NChannels'($urandom);
      bus.Out_Ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NChannels; k++) tb_data[k] = {8'(k), 24'(seq[k])};
      step($urandom_range(0, 99) == 0);
      if (last_grant >= 0) seq[last_grant]++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
